// File: rtl/log_pipe_if.sv
// log_pipe_if: ready/valid bus for the log_pipe ln(1+u) evaluator.
// Carries both the input stream (in_*) and the result stream (out_*).
// master = producer/consumer side around the block, slave = log_pipe itself.
interface log_pipe_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_sat;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sat
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sat
   );
endinterface

// File: rtl/log_pipe.sv
// log_pipe: flow-controlled ln(1+u) evaluator, truncated Taylor series
//   sum_{k=1..N_TERMS} (-1)^(k+1) * u^k / k, one pipeline stage per term.
// Fixed point Q(DW-FRAC-1).FRAC in and out; reciprocal coefficients
// floor(2^FRAC / k) are constants folded at elaboration.
// Optional output clamp: define LOG_PIPE_SAT_EN to saturate out_data to the
// DW-bit range and flag it on out_sat; otherwise out_data wraps, out_sat = 0.
module log_pipe #(
   parameter int DW      = 16,
   parameter int FRAC    = 10,
   parameter int N_TERMS = 4
) (
   input  logic      CLK,
   input  logic      RST_N,
   log_pipe_if.slave bus
);

   localparam int PW  = 2 * DW;        // power register width
   localparam int AW  = 2 * DW + 4;    // accumulator width
   localparam int CW  = FRAC + 2;      // coefficient width, c_1 = 2^FRAC fits as positive
   localparam int XPW = PW + DW;       // full p*x product
   localparam int CPW = PW + CW + 4;   // full p*c product, wide enough to slice AW after shift

   // Reciprocal coefficient c_k = floor(2^FRAC / k)
   function automatic logic [CW-1:0] coef(input int unsigned k);
      int unsigned num;
      num = 32'd1 << FRAC;
      return CW'(num / k);
   endfunction

   logic          v_q   [N_TERMS];
   logic [DW-1:0] x_q   [N_TERMS];
   logic [PW-1:0] p_q   [N_TERMS];
   logic [AW-1:0] acc_q [N_TERMS];

   logic          v_d   [N_TERMS];
   logic [DW-1:0] x_d   [N_TERMS];
   logic [PW-1:0] p_d   [N_TERMS];
   logic [AW-1:0] acc_d [N_TERMS];

   logic          adv;

   // Whole pipeline moves together: advance unless the output is held
   assign adv          = !v_q[N_TERMS-1] || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = v_q[N_TERMS-1];

   // Next-state of every stage: stage 1 loads the input, stage k adds term k
   always_comb begin : stage_next
      logic signed [XPW-1:0] px;
      logic signed [CPW-1:0] pc;
      logic        [PW-1:0]  pn;
      logic        [AW-1:0]  t;
      px = '0;
      pc = '0;
      pn = '0;
      t  = '0;

      v_d[0]   = bus.in_valid;
      x_d[0]   = bus.in_data;
      p_d[0]   = {{(PW-DW){bus.in_data[DW-1]}}, bus.in_data};
      acc_d[0] = {{(AW-DW){bus.in_data[DW-1]}}, bus.in_data};

      for (int unsigned k = 1; k < N_TERMS; k++) begin
         v_d[k] = v_q[k-1];
         x_d[k] = x_q[k-1];

         // p_k = (p_{k-1} * x) >>> FRAC, wrapped to PW
         px = $signed({{DW{p_q[k-1][PW-1]}}, p_q[k-1]})
            * $signed({{PW{x_q[k-1][DW-1]}}, x_q[k-1]});
         px = px >>> FRAC;
         pn = px[PW-1:0];
         p_d[k] = pn;

         // t_k = (p_k * c_k) >>> FRAC; stage index k holds term k+1
         pc = $signed({{(CPW-PW){pn[PW-1]}}, pn})
            * $signed({{(CPW-CW){1'b0}}, coef(k + 1)});
         pc = pc >>> FRAC;
         t  = pc[AW-1:0];

         // Odd terms add, even terms subtract
         if (((k + 1) % 2) == 1)
            acc_d[k] = acc_q[k-1] + t;
         else
            acc_d[k] = acc_q[k-1] - t;
      end
   end

   // Stage registers: async clear, load all stages together on advance
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < N_TERMS; i++) begin
            v_q[i]   <= 1'b0;
            x_q[i]   <= '0;
            p_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      end else if (adv) begin
         for (int unsigned i = 0; i < N_TERMS; i++) begin
            v_q[i]   <= v_d[i];
            x_q[i]   <= x_d[i];
            p_q[i]   <= p_d[i];
            acc_q[i] <= acc_d[i];
         end
      end
   end

`ifdef LOG_PIPE_SAT_EN
   localparam logic signed [AW-1:0] ACC_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic signed [AW-1:0] acc_n;
   assign acc_n = $signed(acc_q[N_TERMS-1]);

   // Clamp the final accumulator into the DW-bit output range
   always_comb begin
      bus.out_data = acc_n[DW-1:0];
      bus.out_sat  = 1'b0;
      if (acc_n > ACC_MAX) begin
         bus.out_data = ACC_MAX[DW-1:0];
         bus.out_sat  = 1'b1;
      end else if (acc_n < ACC_MIN) begin
         bus.out_data = ACC_MIN[DW-1:0];
         bus.out_sat  = 1'b1;
      end
   end
`else
   assign bus.out_data = acc_q[N_TERMS-1][DW-1:0];
   assign bus.out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_log_pipe.sv
// tb_log_pipe: directed + randomized bench for log_pipe (DW=16, FRAC=10,
// N_TERMS=4) with a queue scoreboard fed by an arithmetic series model.
module tb_log_pipe;

   localparam int DW   = 16;
   localparam int FRAC = 10;
   localparam int NT   = 4;
   localparam int PW   = 2 * DW;
   localparam int AW   = 2 * DW + 4;

   logic clk;
   logic rst_n;

   int n_cmp;
   int n_bad;

   logic          seen_valid;
   logic [DW-1:0] seen_data;
   logic          seen_sat;

   logic [DW-1:0] exp_d [$];
   logic          exp_s [$];

   log_pipe_if #(.DW(DW)) bus ();

   log_pipe #(.DW(DW), .FRAC(FRAC), .N_TERMS(NT)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic longint sext(input longint v, input int w);
      longint s;
      s = v << (64 - w);
      return s >>> (64 - w);
   endfunction

   // ln(1+u) series with the fixed-point truncation rules, plain integer math
   function automatic void model(input logic [DW-1:0] xin,
                                 output logic [DW-1:0] d, output logic s);
      longint x, p, acc, t, c;
      x   = longint'($signed(xin));
      p   = x;
      acc = x;
      for (int k = 2; k <= NT; k++) begin
         c   = (64'sd1 <<< FRAC) / k;
         p   = sext((p * x) >>> FRAC, PW);
         t   = (p * c) >>> FRAC;
         acc = sext(((k % 2) == 1) ? acc + t : acc - t, AW);
      end
      d = acc[DW-1:0];
      s = 1'b0;
`ifdef LOG_PIPE_SAT_EN
      if (acc > 32767) begin
         d = 16'h7fff;
         s = 1'b1;
      end else if (acc < -32768) begin
         d = 16'h8000;
         s = 1'b1;
      end
`endif
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, req);
      end
   endtask

   // One clock: sample at negedge, score handshakes, return 1 after posedge
   task automatic tick();
      logic [DW-1:0] md;
      logic          ms;
      @(negedge clk);
      seen_valid = bus.out_valid;
      seen_data  = bus.out_data;
      seen_sat   = bus.out_sat;
      check("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", (exp_d.size() > 0), 1);
         if (exp_d.size() > 0) begin
            check("sb_data", $signed(bus.out_data), $signed(exp_d.pop_front()));
            check("sb_sat", bus.out_sat, exp_s.pop_front());
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         model(bus.in_data, md, ms);
         exp_d.push_back(md);
         exp_s.push_back(ms);
      end
      @(posedge clk);
      #1;
   endtask

   // Send one sample with out_ready high and measure latency and result
   task automatic run_one(input string tag, input logic [DW-1:0] x,
                          input logic signed [63:0] req_d, input logic req_s);
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (n < 20) begin
         tick();
         if (seen_valid) break;
         n++;
      end
      check({tag, "_latency"}, n, NT - 1);
      check({tag, "_data"}, $signed(seen_data), req_d);
      check({tag, "_sat"}, seen_sat, req_s);
   endtask

   initial begin
      logic [DW-1:0] md;
      logic          ms;
      logic signed [63:0] stream_req [3];
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset state, during and after reset
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", $signed(bus.out_data), 0);
      check("rst_out_sat", bus.out_sat, 0);
      check("rst_in_ready", bus.in_ready, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_out_valid", bus.out_valid, 0);
      check("rel_out_data", $signed(bus.out_data), 0);
      check("rel_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

      // Single samples
      run_one("zero", 16'd0, 0, 1'b0);
      run_one("pos", 16'd512, 410, 1'b0);
      run_one("neg", 16'hfe00, -699, 1'b0);
`ifdef LOG_PIPE_SAT_EN
      run_one("satur", 16'h7fff, -32768, 1'b1);
`else
      model(16'h7fff, md, ms);
      run_one("satur", 16'h7fff, $signed(md), 1'b0);
`endif

      // Back-to-back stream with a 5-cycle output stall
      stream_req[0] = 410;
      stream_req[1] = -699;
      stream_req[2] = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd512;
      tick();
      bus.in_data  = 16'hfe00;
      tick();
      bus.in_data  = 16'd0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      check("stall_first_valid", bus.out_valid, 1);
      check("stall_first_data", $signed(bus.out_data), 410);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_in_ready", bus.in_ready, 0);
         check("stall_valid", bus.out_valid, 1);
         check("stall_hold_data", $signed(bus.out_data), 410);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stream_valid", seen_valid, 1);
         check("stream_data", $signed(seen_data), stream_req[i]);
      end
      tick();
      check("stream_no_dup", seen_valid, 0);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = DW'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (NT + 4) tick();
      check("rand_drained", exp_d.size(), 0);

      // Asynchronous reset with samples in flight
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'($urandom_range(0, 2047));
         tick();
      end
      bus.in_valid = 1'b0;
      check("mid_pre_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_async_valid", bus.out_valid, 0);
      check("mid_async_data", $signed(bus.out_data), 0);
      exp_d.delete();
      exp_s.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NT + 4; i++) begin
         tick();
         check("mid_no_stale", seen_valid, 0);
      end

      // Stream resumes cleanly after the mid-stream reset
      run_one("post_rst", 16'd512, 410, 1'b0);
      check("final_sb_empty", exp_d.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
